// File: rtl/load_store_unit.sv
// Data-side load/store sequencer sitting upstream of the instruction/data memory arbiter.
// Each accepted request takes one ACCESS cycle on the memory port, then one CAPTURE cycle
// while the data word comes back. Load results are aligned and extended, then presented
// with a one-cycle load_valid pulse. Misaligned requests are rejected without any memory
// activity.
module load_store_unit #(
  parameter int unsigned WORD_ALIGN_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic        ls_is_store,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [4:0]  ls_rd,
  input  logic [31:0] mem_read_data,
  output logic        ls_busy,
  output logic        stall_pc,
  output logic [31:0] mem_addr,
  output logic        mem_rw_mode,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  output logic        ignore_curr_inst,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        misaligned
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

  state_e      state_q;

  // Request fields latched on acceptance; only the low address bits matter after ACCESS.
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;

  // Registered outputs.
  logic        busy_q;
  logic        stall_q;
  logic [31:0] mem_addr_q;
  logic        rw_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        ignore_q;
  logic        load_valid_q;
  logic [31:0] load_data_q;
  logic [4:0]  load_rd_q;
  logic        misaligned_q;

  // Request decode: alignment check, byte-lane mask, lane-replicated store data, address.
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_addr;

  // Decode the incoming request so the ACCESS-cycle outputs can be registered at acceptance.
  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wdata      = ls_wdata;
    case (ls_size)
      SizeByte: begin
        req_be    = 4'b0001 << ls_addr[1:0];
        req_wdata = {4{ls_wdata[7:0]}};
      end
      SizeHalf: begin
        req_misaligned = ls_addr[0];
        req_be         = 4'b0011 << {ls_addr[1], 1'b0};
        req_wdata      = {2{ls_wdata[15:0]}};
      end
      default: begin
        // Reserved size 11 is handled as a word.
        req_misaligned = (ls_addr[1:0] != 2'b00);
      end
    endcase
    if (WORD_ALIGN_ADDR != 0) begin
      req_addr = {ls_addr[31:2], 2'b00};
    end else begin
      req_addr = ls_addr;
    end
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend.
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // Align and extend the returned word for the latched access.
  always_comb begin
    rd_shifted = mem_read_data;
    load_ext   = mem_read_data;
    case (size_q)
      SizeByte: begin
        rd_shifted = mem_read_data >> {lane_q, 3'b000};
        load_ext   = {{24{rd_shifted[7] & ~unsigned_q}}, rd_shifted[7:0]};
      end
      SizeHalf: begin
        rd_shifted = mem_read_data >> {lane_q[1], 4'b0000};
        load_ext   = {{16{rd_shifted[15] & ~unsigned_q}}, rd_shifted[15:0]};
      end
      default: begin
        load_ext = mem_read_data;
      end
    endcase
  end

  // Access sequencer: IDLE -> ACCESS -> CAPTURE -> IDLE, with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      rd_q         <= 5'd0;
      busy_q       <= 1'b0;
      stall_q      <= 1'b0;
      mem_addr_q   <= 32'd0;
      rw_q         <= 1'b1;
      wdata_q      <= 32'd0;
      be_q         <= 4'b0000;
      ignore_q     <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= 32'd0;
      load_rd_q    <= 5'd0;
      misaligned_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ls_valid) begin
            if (req_misaligned) begin
              // Rejected: memory-side outputs are left untouched.
              misaligned_q <= 1'b1;
            end else begin
              state_q    <= StAccess;
              is_store_q <= ls_is_store;
              size_q     <= ls_size;
              unsigned_q <= ls_unsigned;
              lane_q     <= ls_addr[1:0];
              rd_q       <= ls_rd;
              busy_q     <= 1'b1;
              stall_q    <= 1'b1;
              mem_addr_q <= req_addr;
              rw_q       <= ~ls_is_store;
              be_q       <= req_be;
              wdata_q    <= ls_is_store ? req_wdata : 32'd0;
              ignore_q   <= 1'b0;
            end
          end
        end
        StAccess: begin
          // Hand the port back to fetch; the word returned next cycle is ours.
          state_q  <= StCapture;
          stall_q  <= 1'b0;
          ignore_q <= 1'b1;
          rw_q     <= 1'b1;
          wdata_q  <= 32'd0;
          be_q     <= 4'b0000;
        end
        StCapture: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          ignore_q <= 1'b0;
          if (!is_store_q) begin
            load_valid_q <= 1'b1;
            load_data_q  <= load_ext;
            load_rd_q    <= rd_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ls_busy          = busy_q;
  assign stall_pc         = stall_q;
  assign mem_addr         = mem_addr_q;
  assign mem_rw_mode      = rw_q;
  assign mem_write_data   = wdata_q;
  assign mem_byte_en      = be_q;
  assign ignore_curr_inst = ignore_q;
  assign load_valid       = load_valid_q;
  assign load_data        = load_data_q;
  assign load_rd          = load_rd_q;
  assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word/byte/half loads, half store, misaligned reject,
// busy/back-to-back acceptance and reset in the middle of an access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid;
  logic        ls_is_store;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [4:0]  ls_rd;
  logic [31:0] mem_read_data;
  logic        ls_busy;
  logic        stall_pc;
  logic [31:0] mem_addr;
  logic        mem_rw_mode;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic        ignore_curr_inst;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        misaligned;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.WORD_ALIGN_ADDR(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .ls_valid         (ls_valid),
    .ls_is_store      (ls_is_store),
    .ls_size          (ls_size),
    .ls_unsigned      (ls_unsigned),
    .ls_addr          (ls_addr),
    .ls_wdata         (ls_wdata),
    .ls_rd            (ls_rd),
    .mem_read_data    (mem_read_data),
    .ls_busy          (ls_busy),
    .stall_pc         (stall_pc),
    .mem_addr         (mem_addr),
    .mem_rw_mode      (mem_rw_mode),
    .mem_write_data   (mem_write_data),
    .mem_byte_en      (mem_byte_en),
    .ignore_curr_inst (ignore_curr_inst),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_rd          (load_rd),
    .misaligned       (misaligned)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ls_valid    = 1'b1;
    ls_is_store = st;
    ls_size     = sz;
    ls_unsigned = uns;
    ls_addr     = a;
    ls_wdata    = wd;
    ls_rd       = rd;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},   {31'd0, ls_busy},          32'd0);
    chk({pfx, "_stall"},  {31'd0, stall_pc},         32'd0);
    chk({pfx, "_addr"},   mem_addr,                  32'd0);
    chk({pfx, "_rw"},     {31'd0, mem_rw_mode},      32'd1);
    chk({pfx, "_wdata"},  mem_write_data,            32'd0);
    chk({pfx, "_be"},     {28'd0, mem_byte_en},      32'd0);
    chk({pfx, "_ignore"}, {31'd0, ignore_curr_inst}, 32'd0);
    chk({pfx, "_lvalid"}, {31'd0, load_valid},       32'd0);
    chk({pfx, "_ldata"},  load_data,                 32'd0);
    chk({pfx, "_lrd"},    {27'd0, load_rd},          32'd0);
    chk({pfx, "_misal"},  {31'd0, misaligned},       32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ls_valid = 1'b0; ls_is_store = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'd0; ls_wdata = 32'd0; ls_rd = 5'd0; mem_read_data = 32'd0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Load word @0x104.
    req(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd5);
    tick();
    ls_valid = 1'b0;
    mem_read_data = 32'hDEAD_BEEF;
    chk("lw_acc_stall", {31'd0, stall_pc},    32'd1);
    chk("lw_acc_busy",  {31'd0, ls_busy},     32'd1);
    chk("lw_acc_addr",  mem_addr,             32'h0000_0104);
    chk("lw_acc_be",    {28'd0, mem_byte_en}, 32'hF);
    chk("lw_acc_rw",    {31'd0, mem_rw_mode}, 32'd1);
    chk("lw_acc_wdata", mem_write_data,       32'd0);
    tick();
    chk("lw_cap_ignore", {31'd0, ignore_curr_inst}, 32'd1);
    chk("lw_cap_stall",  {31'd0, stall_pc},         32'd0);
    chk("lw_cap_be",     {28'd0, mem_byte_en},      32'd0);
    chk("lw_cap_busy",   {31'd0, ls_busy},          32'd1);
    chk("lw_cap_lvalid", {31'd0, load_valid},       32'd0);
    tick();
    chk("lw_lvalid", {31'd0, load_valid},       32'd1);
    chk("lw_ldata",  load_data,                 32'hDEAD_BEEF);
    chk("lw_lrd",    {27'd0, load_rd},          32'd5);
    chk("lw_busy",   {31'd0, ls_busy},          32'd0);
    chk("lw_ignore", {31'd0, ignore_curr_inst}, 32'd0);
    tick();
    chk("lw_pulse_end", {31'd0, load_valid}, 32'd0);

    // Signed byte load from lane 3.
    req(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 5'd3);
    tick();
    ls_valid = 1'b0;
    mem_read_data = 32'h8011_2233;
    chk("lb_acc_addr", mem_addr,             32'h0000_0200);
    chk("lb_acc_be",   {28'd0, mem_byte_en}, 32'h8);
    tick();
    tick();
    chk("lb_lvalid", {31'd0, load_valid}, 32'd1);
    chk("lb_ldata",  load_data,           32'hFFFF_FF80);
    chk("lb_lrd",    {27'd0, load_rd},    32'd3);

    // Same, unsigned; request accepted in the cycle load_valid pulses.
    req(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 5'd4);
    tick();
    ls_valid = 1'b0;
    chk("lbu_acc_stall", {31'd0, stall_pc}, 32'd1);
    tick();
    tick();
    chk("lbu_lvalid", {31'd0, load_valid}, 32'd1);
    chk("lbu_ldata",  load_data,           32'h0000_0080);
    chk("lbu_lrd",    {27'd0, load_rd},    32'd4);

    // Signed half load from upper half.
    req(1'b0, 2'b01, 1'b0, 32'h0000_0302, 32'h0, 5'd9);
    tick();
    ls_valid = 1'b0;
    chk("lh_acc_be", {28'd0, mem_byte_en}, 32'hC);
    tick();
    tick();
    chk("lh_ldata", load_data, 32'hFFFF_8011);

    // Store half @0x12.
    req(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_ABCD, 5'd1);
    tick();
    ls_valid = 1'b0;
    chk("sh_acc_rw",    {31'd0, mem_rw_mode}, 32'd0);
    chk("sh_acc_be",    {28'd0, mem_byte_en}, 32'hC);
    chk("sh_acc_wdata", mem_write_data,       32'hABCD_ABCD);
    chk("sh_acc_addr",  mem_addr,             32'h0000_0010);
    tick();
    chk("sh_cap_ignore", {31'd0, ignore_curr_inst}, 32'd1);
    chk("sh_cap_rw",     {31'd0, mem_rw_mode},      32'd1);
    chk("sh_cap_wdata",  mem_write_data,            32'd0);
    tick();
    chk("sh_lvalid", {31'd0, load_valid}, 32'd0);
    chk("sh_ldata_hold", load_data,       32'hFFFF_8011);
    chk("sh_busy",   {31'd0, ls_busy},    32'd0);

    // Misaligned word @0x6.
    req(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd2);
    tick();
    ls_valid = 1'b0;
    chk("mis_pulse", {31'd0, misaligned},  32'd1);
    chk("mis_stall", {31'd0, stall_pc},    32'd0);
    chk("mis_busy",  {31'd0, ls_busy},     32'd0);
    chk("mis_be",    {28'd0, mem_byte_en}, 32'd0);
    chk("mis_addr",  mem_addr,             32'h0000_0010);
    tick();
    chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
    chk("mis_lvalid",    {31'd0, load_valid}, 32'd0);
    chk("mis_stall2",    {31'd0, stall_pc},   32'd0);

    // Busy: second request held from ACCESS onward is ignored until the IDLE cycle.
    req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd7);
    tick();
    req(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 5'd8);
    mem_read_data = 32'h1122_3344;
    chk("bb_acc_addr", mem_addr,             32'h0000_0040);
    chk("bb_acc_rw",   {31'd0, mem_rw_mode}, 32'd1);
    tick();
    chk("bb_cap_ignore", {31'd0, ignore_curr_inst}, 32'd1);
    chk("bb_cap_stall",  {31'd0, stall_pc},         32'd0);
    tick();
    chk("bb_lvalid", {31'd0, load_valid}, 32'd1);
    chk("bb_ldata",  load_data,           32'h1122_3344);
    chk("bb_lrd",    {27'd0, load_rd},    32'd7);
    chk("bb_busy",   {31'd0, ls_busy},    32'd0);
    tick();
    ls_valid = 1'b0;
    chk("bb2_stall", {31'd0, stall_pc},    32'd1);
    chk("bb2_rw",    {31'd0, mem_rw_mode}, 32'd0);
    chk("bb2_addr",  mem_addr,             32'h0000_0080);
    chk("bb2_be",    {28'd0, mem_byte_en}, 32'hF);
    chk("bb2_wdata", mem_write_data,       32'hCAFE_F00D);
    tick();
    tick();
    chk("bb2_lvalid", {31'd0, load_valid}, 32'd0);

    // Reset asserted during CAPTURE of a load.
    req(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd6);
    tick();
    ls_valid = 1'b0;
    mem_read_data = 32'h5555_AAAA;
    tick();
    chk("rmid_cap_ignore", {31'd0, ignore_curr_inst}, 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_vals("rmid");
    rst = 1'b0;
    tick();
    chk("rmid_no_lvalid", {31'd0, load_valid}, 32'd0);
    chk("rmid_idle_busy", {31'd0, ls_busy},    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side access sequencer that sits directly upstream of the instruction/data memory arbiter.
- Accepts one load or store request from execute and drives the arbiter's data-side inputs: stall_pc, mem_addr, mem_rw_mode, mem_write_data, mem_byte_en and ignore_curr_inst.
- Steals exactly one memory-port cycle from instruction fetch per access, then extracts, aligns and sign/zero-extends the returned load data for writeback.
- Flags misaligned accesses without touching memory.

Parameters:
- WORD_ALIGN_ADDR, 1, 1 = mem_addr driven with bits [1:0] cleared; 0 = raw request address passed through.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- ls_valid  input  1  request strobe from execute, sampled only in IDLE
- ls_is_store  input  1  1 = store, 0 = load
- ls_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ls_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
- ls_addr  input  32  byte address
- ls_wdata  input  32  store data, right-justified
- ls_rd  input  5  load destination register
- mem_read_data  input  32  data returned by arbiter (valid in CAPTURE)
- ls_busy  output  1  access in progress; upstream must hold next request
- stall_pc  output  1  to arbiter/PC: data owns memory port this cycle
- mem_addr  output  32  data address to arbiter
- mem_rw_mode  output  1  1 = read, 0 = write
- mem_write_data  output  32  lane-replicated store data
- mem_byte_en  output  4  byte-lane mask
- ignore_curr_inst  output  1  to arbiter: current returned word is data, not an instruction
- load_valid  output  1  one-cycle pulse, load_data/load_rd valid
- load_data  output  32  extended load result
- load_rd  output  5  destination register for load_data
- misaligned  output  1  one-cycle pulse on rejected request

Behaviour:
- Reset values (all outputs registered): state IDLE; ls_busy 0, stall_pc 0, mem_addr 0, mem_rw_mode 1, mem_write_data 0, mem_byte_en 0, ignore_curr_inst 0, load_valid 0, load_data 0, load_rd 0, misaligned 0.
- Reset mid-access returns to IDLE next edge. No load_valid or misaligned is produced for the aborted access.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE, ls_valid=1, aligned request:
  - Latch all request fields.
  - Go to ACCESS. Next cycle: stall_pc=1, ls_busy=1, and data-side outputs driven.
- IDLE, ls_valid=1, misaligned request:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=00.
  - Stay in IDLE; misaligned=1 for the following cycle only; no memory outputs change.
- ACCESS, lasts 1 cycle:
  - stall_pc=1.
  - mem_rw_mode = ~is_store.
  - Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111. The same mask is driven for loads.
  - Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata. Driven as 0 for loads.
  - Then go to CAPTURE.
- CAPTURE, lasts 1 cycle:
  - stall_pc=0, so fetch address resumes.
  - ignore_curr_inst=1 for both loads and stores, because memory read latency is 1 and the returned word belongs to the ACCESS cycle.
  - mem_rw_mode=1, mem_write_data=0, mem_byte_en=0.
  - For a load, mem_read_data is sampled at the end of CAPTURE.
  - Then go to IDLE; ls_busy deasserts in the IDLE cycle.
- Load extraction:
  - Byte: lane = mem_read_data >> (8*addr[1:0]).
  - Half: lane = mem_read_data >> (16*addr[1]).
  - Result is extended to 32 bits per ls_unsigned.
- Load completion: load_valid=1 with load_data and load_rd in the cycle after CAPTURE, i.e. the first IDLE cycle.
  - load_data and load_rd hold their values until the next load completes.
  - Stores never pulse load_valid.
- Latency: request accepted at T → ACCESS T+1 → CAPTURE T+2 → load_valid T+3. A back-to-back request can be accepted at T+3.
- ls_valid while ls_busy=1 is ignored and not queued.
- A new request is accepted in the same cycle load_valid pulses.

Test Plan:
- Load word: addr 0x0000_0104, mem_read_data 0xDEAD_BEEF in CAPTURE → ACCESS: stall_pc=1, mem_addr 0x104, byte_en 1111, rw 1; CAPTURE: ignore_curr_inst=1; T+3: load_valid=1, load_data 0xDEAD_BEEF.
- Signed byte load: addr 0x0000_0203, ls_unsigned=0, mem_read_data 0x80_11_22_33 → load_data 0xFFFF_FF80. Same with ls_unsigned=1 → 0x0000_0080.
- Store half: addr 0x0000_0012, wdata 0x1234_ABCD → ACCESS: rw 0, byte_en 1100, mem_write_data 0xABCD_ABCD, mem_addr 0x10; no load_valid.
- Misaligned word: addr 0x0000_0006 → misaligned pulses 1 cycle; stall_pc, ls_busy and byte_en stay 0; no load_valid.
- Busy and back-to-back: second ls_valid asserted during ACCESS is ignored. A request asserted at T+3 is accepted and its ACCESS occurs at T+4.
- Reset mid-op: assert rst during CAPTURE of a load → next cycle all outputs at reset values; no load_valid pulse.
